multi_queue_rate_meter: RTL and testbench

Parametrised per-queue input rate meter for the user data path. It samples NUM_QUEUES free-running byte counters from the MAC receive queues over a programmable window of clock cycles. It computes a scaled, saturated rate per queue plus a total, with an optional EWMA-smoothed total. It sits beside the register block and feeds hardware registers; rate results are published back-to-back, with no bytes lost between windows.

---
 rtl/rate_meter_pkg.sv | 51 +++++
 rtl/rate_meter_ewma.sv | 43 ++++
 rtl/multi_queue_rate_meter.sv | 208 ++++++++++++++++++++
 tb/tb_multi_queue_rate_meter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rate_meter_pkg.sv
// rtl/rate_meter_pkg.sv - shared types and saturating arithmetic for the rate meter
// States, minimum window length and saturating add/multiply helpers.
package rate_meter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BASELINE,
    COUNT,
    DIFF,
    SUM,
    PUBLISH
  } state_e;

  // Helpers work on a common wide container; callers zero-extend and truncate.
  localparam int MAX_W = 64;
  localparam int PERIOD_MARGIN = 3;

  // Shortest window that still leaves room for DIFF, SUM and PUBLISH.
  function automatic int min_period(input int num_queues);
    return num_queues + PERIOD_MARGIN;
  endfunction

  function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] a,
                                               input logic [MAX_W-1:0] b,
                                               input int width);
    logic [MAX_W:0] sum;
    logic [MAX_W:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = '1;
    lim = lim >> (MAX_W + 1 - width);
    if (sum > lim) begin
      return lim[MAX_W-1:0];
    end
    return sum[MAX_W-1:0];
  endfunction

  function automatic logic [MAX_W-1:0] sat_mul(input logic [MAX_W-1:0] a,
                                               input logic [MAX_W-1:0] b,
                                               input int width);
    logic [2*MAX_W-1:0] prod;
    logic [2*MAX_W-1:0] lim;
    prod = {{MAX_W{1'b0}}, a} * {{MAX_W{1'b0}}, b};
    lim  = '1;
    lim  = lim >> (2 * MAX_W - width);
    if (prod > lim) begin
      return lim[MAX_W-1:0];
    end
    return prod[MAX_W-1:0];
  endfunction

endpackage

// File: rtl/rate_meter_ewma.sv
// rtl/rate_meter_ewma.sv - EWMA smoothing of the published total rate
// Built only with RATE_METER_EWMA_EN; the first load after reset seeds the filter.
module rate_meter_ewma #(
  parameter int RATE_WIDTH = 32,
  parameter int EWMA_SHIFT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [RATE_WIDTH-1:0] total,
  output logic [RATE_WIDTH-1:0] ewma
);

  logic [RATE_WIDTH-1:0] ewma_q, ewma_d;
  logic                  seeded_q, seeded_d;
  logic signed [RATE_WIDTH:0] diff;
  logic signed [RATE_WIDTH:0] step;

  always_comb begin
    ewma_d   = ewma_q;
    seeded_d = seeded_q;
    diff     = $signed({1'b0, total}) - $signed({1'b0, ewma_q});
    step     = diff >>> EWMA_SHIFT;
    if (load) begin
      seeded_d = 1'b1;
      // The result always lies between ewma and total, so it fits RATE_WIDTH.
      ewma_d   = seeded_q ? RATE_WIDTH'($signed({1'b0, ewma_q}) + step) : total;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ewma_q   <= '0;
      seeded_q <= 1'b0;
    end else begin
      ewma_q   <= ewma_d;
      seeded_q <= seeded_d;
    end
  end

  assign ewma = ewma_q;

endmodule

// File: rtl/multi_queue_rate_meter.sv
// rtl/multi_queue_rate_meter.sv - per-queue windowed byte-rate meter with saturated total
// Optional smoothed total under RATE_METER_EWMA_EN; otherwise ewma_rate mirrors total_rate.
module multi_queue_rate_meter
  import rate_meter_pkg::*;
#(
  parameter int NUM_QUEUES   = 4,
  parameter int CNT_WIDTH    = 32,
  parameter int RATE_WIDTH   = 32,
  parameter int PERIOD_WIDTH = 24,
  parameter int SCALE_WIDTH  = 32,
  parameter int EWMA_SHIFT   = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [PERIOD_WIDTH-1:0]          period_cycles,
  input  logic [SCALE_WIDTH-1:0]           scale,
  input  logic [NUM_QUEUES*CNT_WIDTH-1:0]  q_num_bytes_pushed,
  output logic [NUM_QUEUES*RATE_WIDTH-1:0] q_rate,
  output logic [RATE_WIDTH-1:0]            total_rate,
  output logic [RATE_WIDTH-1:0]            ewma_rate,
  output logic                             rate_valid,
  output logic [15:0]                      window_count
);

  localparam int MIN_PERIOD = min_period(NUM_QUEUES);
  localparam int IDX_W      = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;

  state_e                  state_q, state_d;
  logic [PERIOD_WIDTH-1:0] count_q, count_d;
  logic [PERIOD_WIDTH-1:0] eff_period_q, eff_period_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_WIDTH-1:0]    last_q [NUM_QUEUES];
  logic [CNT_WIDTH-1:0]    last_d [NUM_QUEUES];
  logic [CNT_WIDTH-1:0]    snap_q [NUM_QUEUES];
  logic [CNT_WIDTH-1:0]    snap_d [NUM_QUEUES];
  logic [RATE_WIDTH-1:0]   rate_q [NUM_QUEUES];
  logic [RATE_WIDTH-1:0]   rate_d [NUM_QUEUES];
  logic [RATE_WIDTH-1:0]   q_rate_q [NUM_QUEUES];
  logic [RATE_WIDTH-1:0]   q_rate_d [NUM_QUEUES];
  logic [RATE_WIDTH-1:0]   total_rate_q, total_rate_d;
  logic                    rate_valid_q, rate_valid_d;
  logic [15:0]             window_count_q, window_count_d;

  logic                    publish;
  logic                    snap_fire;
  logic [PERIOD_WIDTH-1:0] eff_in;
  logic [CNT_WIDTH-1:0]    cur_delta;
  logic [RATE_WIDTH-1:0]   cur_rate;
  logic [RATE_WIDTH-1:0]   sum_total;

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    eff_period_d   = eff_period_q;
    idx_d          = idx_q;
    last_d         = last_q;
    snap_d         = snap_q;
    rate_d         = rate_q;
    q_rate_d       = q_rate_q;
    total_rate_d   = total_rate_q;
    rate_valid_d   = 1'b0;
    window_count_d = window_count_q;
    publish        = 1'b0;

    eff_in    = (period_cycles < PERIOD_WIDTH'(MIN_PERIOD)) ? PERIOD_WIDTH'(MIN_PERIOD)
                                                            : period_cycles;
    snap_fire = (count_q == eff_period_q - 1'b1);
    // Modular subtraction keeps the delta correct across counter wrap.
    cur_delta = snap_q[idx_q] - last_q[idx_q];
    cur_rate  = RATE_WIDTH'(sat_mul(MAX_W'(cur_delta), MAX_W'(scale), RATE_WIDTH));
    sum_total = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      sum_total = RATE_WIDTH'(sat_add(MAX_W'(sum_total), MAX_W'(rate_q[i]), RATE_WIDTH));
    end

    case (state_q)
      IDLE: begin
        count_d = '0;
        if (enable) state_d = BASELINE;
      end
      BASELINE: begin
        for (int i = 0; i < NUM_QUEUES; i++) begin
          last_d[i] = q_num_bytes_pushed[i*CNT_WIDTH +: CNT_WIDTH];
        end
        eff_period_d = eff_in;
        count_d      = '0;
        state_d      = COUNT;
      end
      COUNT: begin
        if (snap_fire) begin
          for (int i = 0; i < NUM_QUEUES; i++) begin
            snap_d[i] = q_num_bytes_pushed[i*CNT_WIDTH +: CNT_WIDTH];
          end
          count_d      = '0;
          eff_period_d = eff_in;
          idx_d        = '0;
          state_d      = DIFF;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      DIFF: begin
        count_d        = count_q + 1'b1;
        rate_d[idx_q]  = cur_rate;
        last_d[idx_q]  = snap_q[idx_q];
        if (idx_q == IDX_W'(NUM_QUEUES - 1)) begin
          state_d = SUM;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      SUM: begin
        // Output registers load here so they are new during the PUBLISH cycle.
        count_d        = count_q + 1'b1;
        q_rate_d       = rate_q;
        total_rate_d   = sum_total;
        rate_valid_d   = 1'b1;
        window_count_d = window_count_q + 1'b1;
        publish        = 1'b1;
        state_d        = PUBLISH;
      end
      PUBLISH: begin
        count_d = count_q + 1'b1;
        state_d = COUNT;
      end
      default: state_d = IDLE;
    endcase

    // Dropping enable abandons any window still in flight.
    if (!enable) begin
      state_d        = IDLE;
      q_rate_d       = q_rate_q;
      total_rate_d   = total_rate_q;
      rate_valid_d   = 1'b0;
      window_count_d = window_count_q;
      publish        = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      count_q        <= '0;
      eff_period_q   <= PERIOD_WIDTH'(MIN_PERIOD);
      idx_q          <= '0;
      total_rate_q   <= '0;
      rate_valid_q   <= 1'b0;
      window_count_q <= '0;
      for (int i = 0; i < NUM_QUEUES; i++) begin
        last_q[i]   <= '0;
        snap_q[i]   <= '0;
        rate_q[i]   <= '0;
        q_rate_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      eff_period_q   <= eff_period_d;
      idx_q          <= idx_d;
      total_rate_q   <= total_rate_d;
      rate_valid_q   <= rate_valid_d;
      window_count_q <= window_count_d;
      for (int i = 0; i < NUM_QUEUES; i++) begin
        last_q[i]   <= last_d[i];
        snap_q[i]   <= snap_d[i];
        rate_q[i]   <= rate_d[i];
        q_rate_q[i] <= q_rate_d[i];
      end
    end
  end

`ifdef RATE_METER_EWMA_EN
  rate_meter_ewma #(
    .RATE_WIDTH (RATE_WIDTH),
    .EWMA_SHIFT (EWMA_SHIFT)
  ) u_ewma (
    .clk   (clk),
    .reset (reset),
    .load  (publish),
    .total (total_rate_d),
    .ewma  (ewma_rate)
  );
`else
  logic [RATE_WIDTH-1:0] ewma_q, ewma_d;

  always_comb begin
    ewma_d = ewma_q;
    if (publish) ewma_d = total_rate_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ewma_q <= '0;
    else       ewma_q <= ewma_d;
  end

  assign ewma_rate = ewma_q;
`endif

  for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_out
    assign q_rate[g*RATE_WIDTH +: RATE_WIDTH] = q_rate_q[g];
  end

  assign total_rate   = total_rate_q;
  assign rate_valid   = rate_valid_q;
  assign window_count = window_count_q;

endmodule

// File: tb/tb_multi_queue_rate_meter.sv
// tb/tb_multi_queue_rate_meter.sv - scoreboard bench for multi_queue_rate_meter
module tb_multi_queue_rate_meter;

  localparam int NQ  = 4;
  localparam int CW  = 32;
  localparam int RW  = 32;
  localparam int PW  = 24;
  localparam int SW  = 32;
  localparam int ES  = 3;
  localparam int LAT = NQ + 2;
  localparam int MINP = NQ + 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [PW-1:0]     period_cycles;
  logic [SW-1:0]     scale;
  logic [NQ*CW-1:0]  q_num_bytes_pushed;
  logic [NQ*RW-1:0]  q_rate;
  logic [RW-1:0]     total_rate;
  logic [RW-1:0]     ewma_rate;
  logic              rate_valid;
  logic [15:0]       window_count;

  multi_queue_rate_meter #(
    .NUM_QUEUES   (NQ),
    .CNT_WIDTH    (CW),
    .RATE_WIDTH   (RW),
    .PERIOD_WIDTH (PW),
    .SCALE_WIDTH  (SW),
    .EWMA_SHIFT   (ES)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .enable             (enable),
    .period_cycles      (period_cycles),
    .scale              (scale),
    .q_num_bytes_pushed (q_num_bytes_pushed),
    .q_rate             (q_rate),
    .total_rate         (total_rate),
    .ewma_rate          (ewma_rate),
    .rate_valid         (rate_valid),
    .window_count       (window_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          pulse_cyc;
    logic [RW-1:0] q [NQ];
    logic [RW-1:0] total;
    logic [RW-1:0] ewma;
    logic [15:0]   wc;
  } exp_t;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  logic [CW-1:0] cnt [NQ];
  logic [CW-1:0] cur_inc [NQ];
  logic [CW-1:0] inc1 [NQ];
  logic [CW-1:0] inc2 [NQ];
  logic [CW-1:0] bump [NQ];
  logic [CW-1:0] snap_prev [NQ];
  longint        obs_sum [NQ];
  exp_t          sb [$];
  exp_t          got;
  logic [15:0]   exp_wc = '0;
  logic [RW-1:0] exp_ewma = '0;
  bit            ewma_seeded = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pack_counters();
    for (int i = 0; i < NQ; i++) q_num_bytes_pushed[i*CW +: CW] = cnt[i];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NQ; i++) cnt[i] = cnt[i] + cur_inc[i];
    pack_counters();
  endtask

  // Builds the expected record from the bench's own counter values at a snapshot.
  task automatic push_window(input int pulse, input logic [SW-1:0] sc);
    exp_t          e;
    logic [CW-1:0] d;
    logic [63:0]   p;
    logic [63:0]   t;
    longint        diff;
    t = '0;
    for (int i = 0; i < NQ; i++) begin
      d = cnt[i] - snap_prev[i];
      p = {32'b0, d} * {32'b0, sc};
      e.q[i] = (p > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : p[31:0];
      t = t + {32'b0, e.q[i]};
      if (t > 64'hFFFF_FFFF) t = 64'hFFFF_FFFF;
      snap_prev[i] = cnt[i];
    end
    e.total = t[31:0];
`ifdef RATE_METER_EWMA_EN
    if (!ewma_seeded) begin
      exp_ewma = e.total;
    end else begin
      diff     = longint'(e.total) - longint'(exp_ewma);
      exp_ewma = RW'(longint'(exp_ewma) + (diff >>> ES));
    end
    ewma_seeded = 1'b1;
`else
    diff     = 0;
    exp_ewma = e.total + RW'(diff);
`endif
    exp_wc      = exp_wc + 16'd1;
    e.ewma      = exp_ewma;
    e.wc        = exp_wc;
    e.pulse_cyc = pulse;
    sb.push_back(e);
  endtask

  // mode 0: stop after the last window; 1: drop enable mid-DIFF; 2: reset mid-DIFF.
  task automatic run_phase(input int nwin, input int period, input logic [SW-1:0] sc,
                           input int mode);
    int eff;
    int e_cyc;
    int next_snap;
    int pushed;
    eff           = (period < MINP) ? MINP : period;
    period_cycles = PW'(period);
    scale         = sc;
    enable        = 1'b1;
    e_cyc         = cyc;
    for (int i = 0; i < NQ; i++) cur_inc[i] = inc1[i];
    tick();
    for (int i = 0; i < NQ; i++) snap_prev[i] = cnt[i];
    next_snap = cyc + eff;
    pushed    = 0;
    while (pushed < nwin) begin
      tick();
      if (cyc == e_cyc + 3) begin
        for (int i = 0; i < NQ; i++) cnt[i] = cnt[i] + bump[i];
        pack_counters();
      end
      if (cyc == next_snap) begin
        push_window(cyc + LAT, sc);
        pushed++;
        next_snap = next_snap + eff;
        for (int i = 0; i < NQ; i++) cur_inc[i] = inc2[i];
      end
    end
    if (mode == 0) begin
      repeat (LAT + 1) tick();
      enable = 1'b0;
    end else begin
      while (cyc < next_snap + 2) tick();
      if (mode == 1) begin
        enable = 1'b0;
      end else begin
        #2;
        reset = 1'b1;
        #1;
        check("rst_q_rate0", q_rate[RW-1:0], 0);
        check("rst_total", total_rate, 0);
        check("rst_ewma", ewma_rate, 0);
        check("rst_valid", rate_valid, 0);
        check("rst_wcount", window_count, 0);
        sb.delete();
        exp_wc      = '0;
        exp_ewma    = '0;
        ewma_seeded = 1'b0;
      end
    end
    repeat (LAT + 4) tick();
    check("sb_drained", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!reset && rate_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        got = sb.pop_front();
        check("pulse_cycle", cyc, got.pulse_cyc);
        for (int i = 0; i < NQ; i++) begin
          check($sformatf("q_rate%0d", i), q_rate[i*RW +: RW], got.q[i]);
          obs_sum[i] = obs_sum[i] + longint'(q_rate[i*RW +: RW]);
        end
        check("total_rate", total_rate, got.total);
        check("ewma_rate", ewma_rate, got.ewma);
        check("window_count", window_count, got.wc);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    enable        = 1'b0;
    period_cycles = '0;
    scale         = '0;
    for (int i = 0; i < NQ; i++) begin
      cnt[i]     = '0;
      cur_inc[i] = '0;
      inc1[i]    = '0;
      inc2[i]    = '0;
      bump[i]    = '0;
      obs_sum[i] = 0;
    end
    pack_counters();
    repeat (3) tick();
    check("reset_q_rate", q_rate, 0);
    check("reset_total", total_rate, 0);
    check("reset_ewma", ewma_rate, 0);
    check("reset_valid", rate_valid, 0);
    check("reset_wcount", window_count, 0);
    tick();
    reset = 1'b0;
    repeat (3) tick();

    // Steady +5/cycle, period 100, scale 10.
    for (int i = 0; i < NQ; i++) begin inc1[i] = 5; inc2[i] = 5; end
    run_phase(3, 100, 10, 0);

    // Queue 0 wraps through zero inside the window.
    for (int i = 0; i < NQ; i++) begin inc1[i] = 1; inc2[i] = 1; end
    inc1[0] = 4;
    inc2[0] = 4;
    cnt[0]  = 32'hFFFF_FF00 - 32'd4;
    pack_counters();
    run_phase(2, 128, 3, 0);

    // Full-scale multiplier: small deltas saturate rates and total.
    for (int i = 0; i < NQ; i++) begin inc1[i] = 0; inc2[i] = 0; end
    bump[0] = 2;
    bump[1] = 1;
    run_phase(2, 2, 32'hFFFF_FFFF, 0);
    for (int i = 0; i < NQ; i++) bump[i] = 0;

    // Clamped period, back-to-back windows, then enable drops mid-DIFF.
    for (int i = 0; i < NQ; i++) begin
      inc1[i]    = CW'(i + 1);
      inc2[i]    = CW'(i + 1);
      obs_sum[i] = 0;
    end
    run_phase(5, 2, 1, 1);
    for (int i = 0; i < NQ; i++) begin
      check($sformatf("byte_sum%0d", i), obs_sum[i], longint'((i + 1) * MINP * 5));
    end
    repeat (3) tick();

    // Reset in the middle of DIFF, then restart straight out of reset.
    for (int i = 0; i < NQ; i++) begin inc1[i] = 1; inc2[i] = 1; end
    run_phase(1, 7, 1, 2);
    for (int i = 0; i < NQ; i++) begin inc1[i] = 0; inc2[i] = 0; end
    inc1[0] = 8;
    tick();
    reset = 1'b0;
    run_phase(2, 100, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
